// File: rtl/sequencer_step_player.sv
// rtl/sequencer_step_player.sv - single-track 8-step pattern player with decaying sustain output
module sequencer_step_player #(
  parameter logic [7:0]  PLAY_ON   = 8'h00,
  parameter int unsigned DECAY_DIV = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       toggle,
  input  logic [2:0] beat,
  input  logic       sequencer_on,
  output logic [3:0] note_sustain
);

  // Decay prescaler width; a divide-by-one still keeps a 1-bit counter.
  localparam int unsigned       CW       = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(DECAY_DIV - 1);

  logic [7:0]    r_pattern;
  logic          r_toggle_q;
  logic [2:0]    r_beat_q;
  logic          r_on_q;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_sustain;

  logic w_toggle_rise;
  logic w_step_start;
  logic w_hit;

  assign w_toggle_rise = toggle & ~r_toggle_q;
  // A new beat value, or the first enabled cycle, starts a step.
  assign w_step_start  = sequencer_on & ((beat != r_beat_q) | ~r_on_q);
  // The trigger looks at the pattern before any same-cycle edit lands.
  assign w_hit         = w_step_start & r_pattern[beat];
  assign note_sustain  = r_sustain;

  // Input history and pattern editing; history tracks inputs even while stopped.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_pattern  <= PLAY_ON;
      r_toggle_q <= 1'b0;
      r_beat_q   <= 3'd0;
      r_on_q     <= 1'b0;
    end else begin
      r_toggle_q <= toggle;
      r_beat_q   <= beat;
      r_on_q     <= sequencer_on;
      if (w_toggle_rise) begin
        r_pattern[beat] <= ~r_pattern[beat];
      end
    end
  end

  // Sustain envelope: load full on an active step, decay one unit per DECAY_DIV clocks.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_sustain <= 4'd0;
      r_cnt     <= '0;
    end else if (!sequencer_on) begin
      r_sustain <= 4'd0;
      r_cnt     <= '0;
    end else if (w_hit) begin
      r_sustain <= 4'd15;
      r_cnt     <= '0;
    end else if (r_sustain != 4'd0) begin
      if (r_cnt == CNT_LAST) begin
        r_sustain <= r_sustain - 4'd1;
        r_cnt     <= '0;
      end else begin
        r_cnt     <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sequencer_step_player.sv
// tb/tb_sequencer_step_player.sv - directed self-checking bench for sequencer_step_player
module tb_sequencer_step_player;

  logic       clk = 1'b0;

  logic       a_rst, a_tog, a_on;
  logic [2:0] a_beat;
  logic [3:0] a_sus;

  logic       b_rst, b_tog, b_on;
  logic [2:0] b_beat;
  logic [3:0] b_sus;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sequencer_step_player #(.PLAY_ON(8'h01), .DECAY_DIV(1)) u_dut_a (
    .clk          (clk),
    .n_rst        (a_rst),
    .toggle       (a_tog),
    .beat         (a_beat),
    .sequencer_on (a_on),
    .note_sustain (a_sus)
  );

  sequencer_step_player #(.PLAY_ON(8'h00), .DECAY_DIV(4)) u_dut_b (
    .clk          (clk),
    .n_rst        (b_rst),
    .toggle       (b_tog),
    .beat         (b_beat),
    .sequencer_on (b_on),
    .note_sustain (b_sus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_tog = 1'b0; a_on = 1'b1; a_beat = 3'd7;
    b_rst = 1'b1; b_tog = 1'b0; b_on = 1'b1; b_beat = 3'd3;

    // ---------------- instance A: PLAY_ON=01, DECAY_DIV=1 ----------------
    tick(); tick();
    check("a_reset", a_sus, 4'd0);
    a_rst = 1'b0;
    tick();
    check("a_enable_inactive", a_sus, 4'd0);
    tick();
    check("a_idle", a_sus, 4'd0);
    // wrap 7 -> 0 onto the active step
    a_beat = 3'd0;
    tick();
    check("a_wrap_load", a_sus, 4'd15);
    for (int i = 14; i >= 0; i--) begin
      tick();
      check($sformatf("a_decay_%0d", i), a_sus, 4'(i));
    end
    tick();
    check("a_hold0_1", a_sus, 4'd0);
    tick();
    check("a_hold0_2", a_sus, 4'd0);

    // drop run enable mid-decay
    a_beat = 3'd7; tick();
    check("a_to_inactive", a_sus, 4'd0);
    a_beat = 3'd0; tick();
    check("a_reload", a_sus, 4'd15);
    tick(); check("a_d14", a_sus, 4'd14);
    tick(); check("a_d13", a_sus, 4'd13);
    a_on = 1'b0; tick();
    check("a_off", a_sus, 4'd0);
    a_on = 1'b1; tick();
    check("a_reenable", a_sus, 4'd15);
    tick(); check("a_re_d14", a_sus, 4'd14);

    // clear step 0, then reset mid-note must restore PLAY_ON
    a_tog = 1'b1; tick();
    check("a_edit_no_cut", a_sus, 4'd13);
    a_tog = 1'b0;
    a_rst = 1'b1; tick();
    check("a_reset_mid", a_sus, 4'd0);
    a_rst = 1'b0; tick();
    check("a_pattern_restored", a_sus, 4'd15);

    // reprogram pattern to step 2 only while stopped
    a_on = 1'b0; tick();
    check("a_off2", a_sus, 4'd0);
    a_tog = 1'b1; tick();
    a_tog = 1'b0; a_beat = 3'd2; tick();
    a_tog = 1'b1; tick();
    a_tog = 1'b0; tick();
    check("a_off_edit", a_sus, 4'd0);
    a_on = 1'b1; a_beat = 3'd0; tick();
    check("a_sweep_b0", a_sus, 4'd0);
    a_beat = 3'd1; tick(); check("a_sweep_b1", a_sus, 4'd0);
    a_beat = 3'd2; tick(); check("a_sweep_b2", a_sus, 4'd15);
    a_beat = 3'd3; tick(); check("a_sweep_b3", a_sus, 4'd14);
    a_beat = 3'd4; tick(); check("a_sweep_b4", a_sus, 4'd13);
    a_beat = 3'd5; tick(); check("a_sweep_b5", a_sus, 4'd12);
    a_beat = 3'd6; tick(); check("a_sweep_b6", a_sus, 4'd11);
    a_beat = 3'd7; tick(); check("a_sweep_b7", a_sus, 4'd10);
    a_beat = 3'd0; tick(); check("a_sweep_w0", a_sus, 4'd9);
    a_beat = 3'd1; tick(); check("a_sweep_w1", a_sus, 4'd8);

    // ---------------- instance B: PLAY_ON=00, DECAY_DIV=4 ----------------
    b_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("b_silent_%0d", i), b_sus, 4'd0);
    end
    b_tog = 1'b1; tick();
    check("b_edit_no_trigger", b_sus, 4'd0);
    b_tog = 1'b0; tick();
    b_beat = 3'd4; tick();
    check("b_inactive4", b_sus, 4'd0);
    b_beat = 3'd3; tick();
    check("b_load", b_sus, 4'd15);
    for (int i = 0; i < 3; i++) begin
      tick(); check($sformatf("b_hold15_%0d", i), b_sus, 4'd15);
    end
    tick(); check("b_first_dec", b_sus, 4'd14);
    for (int i = 0; i < 3; i++) begin
      tick(); check($sformatf("b_hold14_%0d", i), b_sus, 4'd14);
    end
    tick(); check("b_second_dec", b_sus, 4'd13);

    b_on = 1'b0; tick();
    check("b_off", b_sus, 4'd0);
    // second pulse clears step 3
    b_tog = 1'b1; tick();
    b_tog = 1'b0; tick();
    b_on = 1'b1; tick();
    check("b_step3_cleared", b_sus, 4'd0);
    b_on = 1'b0; tick();
    // held toggle flips only once
    b_tog = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    b_tog = 1'b0; tick();
    b_on = 1'b1; tick();
    check("b_held_toggle_once", b_sus, 4'd15);

    // toggle rise and step start on the same edge use the old bit
    b_on = 1'b0; tick();
    check("b_off3", b_sus, 4'd0);
    b_beat = 3'd2; b_on = 1'b1; b_tog = 1'b1; tick();
    check("b_same_edge_old_bit", b_sus, 4'd0);
    b_tog = 1'b0; b_beat = 3'd5; tick();
    check("b_inactive5", b_sus, 4'd0);
    b_beat = 3'd2; tick();
    check("b_new_bit_applies", b_sus, 4'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequencer_step_player.md
# sequencer_step_player

Single-track step player for the 8-step sequencer. It holds an 8-bit on/off pattern, one bit per beat. The user edits the pattern with a toggle input at the current beat. While the sequencer runs, the block emits a 4-bit decaying sustain level each time the global beat counter enters an active step. It sits between the beat counter and the note/voice mixer, and one instance is used per sequencer track.

## Interface
Parameters:
- PLAY_ON, default 8'h00: pattern reset value; bit i = step i active.
- DECAY_DIV, default 1: clocks per one-unit decrement of note_sustain (1..65535).

Ports:
- clk, input, 1: system clock; all state changes on rising edge.
- n_rst, input, 1: reset. Synchronous and active-high: when n_rst = 1 at a rising clk edge, all state is reset.
- toggle, input, 1: edit strobe. A rising edge flips pattern[beat].
- beat, input, 3: current step index 0..7 from the beat counter.
- sequencer_on, input, 1: run enable.
- note_sustain, output, 4: sustain level for this track. 0 = silent, 15 = full.

## Operation
- State:
  - pattern[7:0]
  - toggle_q (previous toggle)
  - beat_q (previous beat)
  - on_q (previous sequencer_on)
  - decay counter (width ceil(log2(DECAY_DIV)), minimum 1 bit)
  - sustain[3:0], which drives note_sustain directly.
- Reset values:
  - pattern = PLAY_ON
  - toggle_q = 0, beat_q = 0, on_q = 0
  - decay counter = 0
  - note_sustain = 0
- Edit:
  - toggle_rise = toggle & ~toggle_q.
  - On toggle_rise, pattern[beat] inverts. No other bit changes.
  - Editing works whether sequencer_on is 0 or 1.
  - X/unknown toggle before first drive must not corrupt state: toggle_q resets to 0.
- Step start:
  - step_start = sequencer_on & ((beat != beat_q) | ~on_q).
  - This covers a new beat value, and the first cycle after the sequencer is enabled.
- Sustain update, in priority order each clock:
  1. Reset.
  2. If sequencer_on = 0: sustain = 0, decay counter = 0.
  3. If step_start and pattern[beat] = 1 (pattern value before any same-cycle toggle): sustain = 15, decay counter = 0.
  4. Else if sustain > 0:
     - If decay counter = DECAY_DIV-1: sustain decrements by 1 and the counter clears.
     - Otherwise the counter increments.
  5. Else: hold 0.
- sustain saturates at 0; it never wraps to 15.
- A step start onto an inactive step does not cut a decaying note; decay continues.
- beat wrap 7 -> 0 counts as a beat change (values differ).
- beat_q, on_q and toggle_q load their inputs every clock, including while sequencer_on = 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Toggle latency:
  - toggle rises before edge k, so edge k sees toggle = 1 and toggle_q = 0; pattern flips at edge k.
  - Holding toggle high flips the bit only once.
- Step latency: beat changes before edge k into an active step -> note_sustain = 15 after edge k.
- Decay with DECAY_DIV = 1: 15, 14, ..., 0 on successive clocks; reaches 0 at 15 clocks after load.
- Simultaneous toggle rise and step start at the same edge:
  - The step trigger uses the old pattern bit.
  - The new bit applies from the next step start onward.
- sequencer_on falling: note_sustain = 0 after that edge.
- Re-enable: the first enabled edge is a step start on the current beat.
- Reset mid-note: note_sustain = 0 and pattern = PLAY_ON after the edge.

## Test plan
- Reset with PLAY_ON = 0, sequencer_on = 1, beat = 3 held: note_sustain stays 0 for 4+ clocks.
- At beat = 3, pulse toggle high one clock, low, high, low: pattern[3] goes 1 then 0. Hold toggle high 3 clocks: bit flips once.
- PLAY_ON = 8'h01, DECAY_DIV = 1, sequencer_on = 1, beat steps 7 -> 0: note_sustain = 15 after the edge, then 14, 13, ... reaching 0 after 15 more clocks, holding 0.
- Toggle step 2 on, then sweep beat 0..7, 0, 1 one per clock: note_sustain = 15 only after the edge where beat becomes 2, decaying through the following beats.
- DECAY_DIV = 4, active step hit: note_sustain stays at 15 for 4 clocks, then decrements once per 4 clocks.
- Drop sequencer_on mid-decay -> note_sustain = 0 next edge. Raise it with beat on an active step -> 15 next edge. Assert n_rst mid-note -> note_sustain 0, pattern = PLAY_ON.
